mem_port_arbiter: RTL and testbench

//  Shares the core's single memory bus port between instruction fetch (IF) and load/store (MEM).

---
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one registered req/ack memory bus between instruction fetch and load/store.
// MEM has fixed priority; a hung bus transaction is aborted after TIMEOUT_CYCLES with an error.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_ack,
  output logic                    if_err,
  input  logic                    mem_req,
  input  logic                    mem_we,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_ack,
  output logic                    mem_err,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic [DATA_WIDTH/8-1:0] bus_be,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  input  logic                    bus_ack,
  output logic                    if_stall_req,
  output logic                    mem_stall_req
);

  localparam int BE_WIDTH    = DATA_WIDTH / 8;
  localparam bit TIMEOUT_EN  = (TIMEOUT_CYCLES > 0);
  localparam int TIMER_WIDTH = (TIMEOUT_CYCLES > 0) ? (($clog2(TIMEOUT_CYCLES + 1) > 0) ?
                               $clog2(TIMEOUT_CYCLES + 1) : 1) : 1;
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
    TIMER_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_MEM = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                 state;
  logic [TIMER_WIDTH-1:0] timer;
  logic                   timeout_hit;

  // The last permitted wait cycle; a bus_ack arriving in this same cycle still wins.
  assign timeout_hit = TIMEOUT_EN && (timer == TIMER_LAST);

  assign if_stall_req  = if_req & ~if_ack;
  assign mem_stall_req = mem_req & ~mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      if_rdata  <= '0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      mem_rdata <= '0;
      mem_ack   <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            state     <= GNT_MEM;
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
            bus_be    <= mem_be;
            timer     <= '0;
          end else if (if_req) begin
            state     <= GNT_IF;
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
            bus_be    <= {BE_WIDTH{1'b1}};
            timer     <= '0;
          end
        end

        GNT_IF, GNT_MEM: begin
          if (bus_ack || timeout_hit) begin
            state   <= DONE;
            bus_req <= 1'b0;
            if (state == GNT_MEM) begin
              mem_ack   <= 1'b1;
              mem_err   <= ~bus_ack;
              mem_rdata <= bus_ack ? bus_rdata : '0;
            end else begin
              if_ack   <= 1'b1;
              if_err   <= ~bus_ack;
              if_rdata <= bus_ack ? bus_rdata : '0;
            end
          end else if (TIMEOUT_EN) begin
            timer <= timer + 1'b1;
          end
        end

        DONE: begin
          // Requests are deliberately not sampled here; the requester sees its ack first.
          state   <= IDLE;
          if_err  <= 1'b0;
          mem_err <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter: a bus slave model predicts each
// completion when a transaction starts, and an independent monitor checks every ack.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int T  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ack, if_err;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic [BW-1:0] mem_be = '0;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack, mem_err;
  logic          bus_req, bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [BW-1:0] bus_be;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_ack = 1'b0;
  logic          if_stall_req, mem_stall_req;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .if_stall_req(if_stall_req), .mem_stall_req(mem_stall_req)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
    int            at;
  } exp_t;

  exp_t mem_q[$];
  exp_t if_q[$];
  exp_t me, ie, ne;

  int            forced_k = -1;
  bit            forced_data_en = 1'b0;
  logic [DW-1:0] forced_data = '0;
  bit            snap_mem_req = 1'b0;
  bit            snap_if_req = 1'b0;

  bit            s_in_txn = 1'b0;
  bit            s_owner_mem = 1'b0;
  int            s_k = 0;
  int            s_gidx = 0;
  logic [DW-1:0] s_data = '0;

  task automatic chk(input string name, input longint got, input longint need);
    total++;
    if (got != need) begin
      bad++;
      $display("FAIL %s got=%0d need=%0d (cyc=%0d)", name, got, need, cyc);
    end
  endtask

  // Request values as seen during the previous cycle, i.e. the cycle the arbiter decided in.
  initial forever begin
    @(negedge clk);
    snap_mem_req = mem_req;
    snap_if_req  = if_req;
  end

  task automatic check_fields(input bit m);
    total++;
    if (m) begin
      if (bus_we !== mem_we || bus_addr !== mem_addr || bus_wdata !== mem_wdata || bus_be !== mem_be) begin
        bad++;
        $display("FAIL bus_fields_mem cyc=%0d got we=%b addr=%h wdata=%h be=%b need we=%b addr=%h wdata=%h be=%b",
                 cyc, bus_we, bus_addr, bus_wdata, bus_be, mem_we, mem_addr, mem_wdata, mem_be);
      end
    end else begin
      if (bus_we !== 1'b0 || bus_addr !== if_addr || bus_be !== {BW{1'b1}}) begin
        bad++;
        $display("FAIL bus_fields_if cyc=%0d got we=%b addr=%h be=%b need we=0 addr=%h be=%b",
                 cyc, bus_we, bus_addr, bus_be, if_addr, {BW{1'b1}});
      end
    end
  endtask

  // Bus slave: picks an ack delay per transaction and predicts the requester's completion.
  initial forever begin
    @(posedge clk);
    #1;
    bus_ack = 1'b0;
    if (!rst_n) begin
      s_in_txn = 1'b0;
    end else begin
      if (s_in_txn && !bus_req) begin
        s_in_txn = 1'b0;
      end else if (!s_in_txn && bus_req) begin
        s_in_txn    = 1'b1;
        s_gidx      = 0;
        s_owner_mem = snap_mem_req;
        total++;
        if (!snap_mem_req && !snap_if_req) begin
          bad++;
          $display("FAIL grant_without_req cyc=%0d got bus_req=1 need no grant", cyc);
        end
        s_k    = (forced_k >= 0) ? forced_k : int'($urandom_range(0, T + 1));
        s_data = forced_data_en ? forced_data : $urandom;
        ne.err  = (s_k >= T);
        ne.data = (s_k >= T) ? '0 : s_data;
        ne.at   = (s_k >= T) ? (cyc + T) : (cyc + s_k + 1);
        if (s_owner_mem) mem_q.push_back(ne);
        else if_q.push_back(ne);
      end
      if (s_in_txn) begin
        check_fields(s_owner_mem);
        if (s_gidx == s_k && s_k < T) begin
          bus_ack   = 1'b1;
          bus_rdata = s_data;
        end
        s_gidx++;
      end else if ($urandom_range(0, 5) == 0) begin
        bus_ack   = 1'b1;
        bus_rdata = $urandom;
      end
    end
  end

  // Monitor: stall outputs every cycle, and each ack against the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("mem_stall_req", longint'(mem_stall_req), longint'(mem_req & ~mem_ack));
      chk("if_stall_req", longint'(if_stall_req), longint'(if_req & ~if_ack));
      if (mem_ack && if_ack) chk("both_acks", 1, 0);
      if (mem_ack) begin
        total++;
        if (mem_q.size() == 0) begin
          bad++;
          $display("FAIL spurious_mem_ack cyc=%0d got ack with nothing outstanding", cyc);
        end else begin
          me = mem_q.pop_front();
          $display("txn mem cyc=%0d err=%b rdata=%h", cyc, mem_err, mem_rdata);
          if (mem_err !== me.err || mem_rdata !== me.data || cyc != me.at || bus_req !== 1'b0) begin
            bad++;
            $display("FAIL mem_completion got err=%b rdata=%h cyc=%0d bus_req=%b need err=%b rdata=%h cyc=%0d bus_req=0",
                     mem_err, mem_rdata, cyc, bus_req, me.err, me.data, me.at);
          end
        end
      end
      if (if_ack) begin
        total++;
        if (if_q.size() == 0) begin
          bad++;
          $display("FAIL spurious_if_ack cyc=%0d got ack with nothing outstanding", cyc);
        end else begin
          ie = if_q.pop_front();
          $display("txn if  cyc=%0d err=%b rdata=%h", cyc, if_err, if_rdata);
          if (if_err !== ie.err || if_rdata !== ie.data || cyc != ie.at || bus_req !== 1'b0) begin
            bad++;
            $display("FAIL if_completion got err=%b rdata=%h cyc=%0d bus_req=%b need err=%b rdata=%h cyc=%0d bus_req=0",
                     if_err, if_rdata, cyc, bus_req, ie.err, ie.data, ie.at);
          end
        end
      end
    end
  end

  // Requesters: assert a level request, hold it through the ack cycle, drop it the cycle after.
  task automatic do_mem(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [BW-1:0] be, output int lat);
    int st;
    st = cyc;
    lat = -1;
    mem_we = we; mem_addr = a; mem_wdata = wd; mem_be = be; mem_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_ack) begin
        lat = cyc - st;
        break;
      end
    end
    if (lat < 0) chk("mem_ack_timeout", 0, 1);
    @(posedge clk);
    #1;
    mem_req = 1'b0;
  endtask

  task automatic do_if(input logic [AW-1:0] a, output int lat);
    int st;
    st = cyc;
    lat = -1;
    if_addr = a; if_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if_ack) begin
        lat = cyc - st;
        break;
      end
    end
    if (lat < 0) chk("if_ack_timeout", 0, 1);
    @(posedge clk);
    #1;
    if_req = 1'b0;
  endtask

  initial begin
    int lat;
    int lat2;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_bus_req", longint'(bus_req), 0);
    chk("rst_bus_we", longint'(bus_we), 0);
    chk("rst_acks", longint'({if_ack, mem_ack, if_err, mem_err}), 0);
    chk("rst_bus_addr", longint'(bus_addr), 0);
    chk("rst_bus_wdata_be", longint'({bus_wdata, bus_be}), 0);
    chk("rst_rdata", longint'(if_rdata | mem_rdata), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load: bus_ack two cycles into the grant, ack four cycles after the request.
    forced_k = 2; forced_data_en = 1'b1; forced_data = 32'hDEADBEEF;
    do_mem(1'b0, 32'h100, 32'h0, 4'hF, lat);
    chk("load_latency", lat, 4);

    // Store: fields must stay on the bus until ack.
    forced_k = 3; forced_data = 32'hCAFEF00D;
    do_mem(1'b1, 32'h200, 32'h1234, 4'b0011, lat);
    chk("store_latency", lat, 5);

    // Timeout with no ack, then ack landing on the very last allowed cycle.
    forced_k = T;
    do_if(32'h300, lat);
    chk("timeout_latency", lat, T + 1);
    forced_k = T - 1; forced_data = 32'h5A5A5A5A;
    do_if(32'h304, lat);
    chk("race_latency", lat, T + 1);

    // Contention: both requests in the same cycle, MEM first, IF after an IDLE cycle.
    forced_k = 1; forced_data_en = 1'b0;
    fork
      do_mem(1'b0, 32'h400, 32'h0, 4'hF, lat);
      do_if(32'h500, lat2);
    join
    chk("contention_mem_latency", lat, 3);
    chk("contention_if_latency", lat2, 7);

    // Asynchronous reset in the middle of a MEM grant.
    forced_k = 100;
    mem_we = 1'b1; mem_addr = 32'h600; mem_wdata = 32'h77; mem_be = 4'hF; mem_req = 1'b1;
    @(posedge clk);
    #3;
    chk("pre_reset_bus_req", longint'(bus_req), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_bus_req", longint'(bus_req), 0);
    chk("async_reset_no_ack", longint'(mem_ack), 0);
    mem_q.delete();
    if_q.delete();
    mem_req = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    forced_k = 0;
    do_mem(1'b0, 32'h700, 32'h0, 4'hF, lat);
    chk("post_reset_latency", lat, 2);

    // Random traffic from both requesters concurrently.
    forced_k = -1;
    fork
      begin
        int l1;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          do_mem(1'($urandom_range(0, 1)), $urandom, $urandom, BW'($urandom_range(0, 15)), l1);
        end
      end
      begin
        int l2;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          do_if($urandom, l2);
        end
      end
    join

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", longint'(mem_q.size() + if_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
